tile_spawn_ctrl: RTL and testbench
==================================

// Module: tile_spawn_ctrl
// PURPOSE
// Sequences new-tile placement on the 4x4 2048 board. On a spawn or game-start
// request it takes the free-running random cell index and snapshots the board
// occupancy. It then scans forward, with wrap, to the first empty cell and issues
// one board write of a 2-tile or a 4-tile. It sits between the move/merge engine,
// the position randomizer and the board register file.
// PARAMETERS
// N_CELLS      16      board cells; must equal 2**POS_W
// POS_W        4       cell index width
// VAL_W        4       tile code width (log2 of tile value: 1 = 2, 2 = 4)
// FOUR_THRESH  2       a 4-tile is spawned when lfsr[3:0] < FOUR_THRESH
// LFSR_SEED    8'hA5   LFSR reset value; must be nonzero
// PORTS
// clk         in   1        system clock, rising edge
// rst_n       in   1        asynchronous reset, active low
// spawn_req   in   1        one-cycle pulse after a valid move: spawn 1 tile
// init_req    in   1        one-cycle pulse at game start: spawn 2 tiles
// rand_pos    in   POS_W    free-running cell index from the randomizer
// occupancy   in   N_CELLS  bit i = 1 when cell i holds a tile
// busy        out  1        high from the cycle after acceptance until done
// wr_en       out  1        one-cycle board write strobe
// wr_pos      out  POS_W    cell written; valid while wr_en = 1
// wr_val      out  VAL_W    tile code written; valid while wr_en = 1
// done        out  1        one-cycle pulse when the request completes
// board_full  out  1        one-cycle pulse together with done: no empty cell
// req_drop    out  1        one-cycle pulse: a request arrived while busy
// BEHAVIOUR
// - Reset (async, rst_n = 0):
//   - state is IDLE; every output is 0; idx, snap and remaining are 0; lfsr = LFSR_SEED.
//   - A reset in mid-operation aborts immediately. No partial write completes.
// - The LFSR is 8 bits (x^8+x^6+x^5+x^4+1). It advances every cycle and is never 0.
// - FSM states: IDLE, SCAN, WRITE, DONE, FULL.
// - IDLE: a request is accepted in cycle T when spawn_req or init_req is high.
//   - At T it captures idx = rand_pos, snap = occupancy, remaining = 1 (spawn) or 2 (init).
//   - It also clears cnt and moves to SCAN.
//   - If init_req and spawn_req are high together, init wins.
// - SCAN: one cell is checked per cycle.
//   - If snap[idx] == 0, go to WRITE.
//   - Otherwise idx = idx + 1 (mod N_CELLS) and cnt = cnt + 1.
//   - When cnt reaches N_CELLS-1 and the cell is still occupied, go to FULL.
//   - Latency: with k occupied cells skipped, wr_en rises at T+2+k.
// - WRITE: wr_en = 1 for exactly one cycle.
//   - wr_pos = idx.
//   - wr_val = 2 if lfsr[3:0] < FOUR_THRESH, else 1.
//   - The same cycle sets snap[idx] = 1 and decrements remaining.
//   - If remaining was 2: idx = rand_pos sampled this cycle, cnt = 0, go to SCAN.
//   - Otherwise go to DONE.
// - DONE: done = 1 for one cycle, then IDLE.
// - FULL: done = 1 and board_full = 1 for one cycle, then IDLE.
//   - An init that placed one tile and then hits full reports both pulses.
// - busy = 1 in SCAN, WRITE, DONE and FULL. A new request is accepted no earlier
//   than the cycle after done.
// - A request seen while state != IDLE is dropped and pulses req_drop for one cycle.
//   It is never queued.
// - occupancy changes after acceptance are ignored; only the snapshot is used.
// - All outputs are registered.
// STRUCTURE
// - Shared package tile_pkg: N_CELLS, POS_W, VAL_W, tile codes TILE_2 = 1 and
//   TILE_4 = 2, FSM state encoding.
// - One sub-module: spawn_lfsr (8-bit Fibonacci LFSR, seed parameter, async reset).
// - Remaining logic is a single FSM with the idx/cnt/remaining/snap datapath.
// TESTING
// 1. Empty board, spawn_req at T with rand_pos=5 -> wr_en at T+2, wr_pos=5,
//    done at T+3, busy high T+1..T+3.
// 2. occupancy=16'h00E0, spawn_req with rand_pos=5 -> cells 5,6,7 skipped,
//    wr_pos=8 at T+5.
// 3. occupancy=16'h8000, rand_pos=15 -> wraps, wr_pos=0 at T+3.
// 4. occupancy=16'hFFFF, spawn_req -> no wr_en, done and board_full together at T+17.
// 5. init_req on an empty board -> two wr_en pulses at distinct wr_pos, then one done.
// 6. spawn_req during SCAN -> req_drop pulse, one write only.
// 7. Reset asserted in SCAN -> all outputs 0 at once, IDLE after release.
// 8. Over 10k spawns wr_val is always 1 or 2, with a 4-tile ratio of about
//    FOUR_THRESH/16.

Source files
------------

// File: rtl/tile_spawn_ctrl_pkg.sv
// Shared types and constants for the 2048 tile spawner.
// Board geometry, tile codes and FSM state encoding.
package tile_pkg;

  localparam int N_CELLS = 16;
  localparam int POS_W   = 4;
  localparam int VAL_W   = 4;

  localparam logic [VAL_W-1:0] TILE_2 = 4'd1;
  localparam logic [VAL_W-1:0] TILE_4 = 4'd2;

  localparam logic [POS_W-1:0] LAST_CNT =
    POS_W'(N_CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_DONE,
    S_FULL
  } state_e;

  function automatic logic [POS_W-1:0] pos_inc(
    input logic [POS_W-1:0] p
  );
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/tile_spawn_ctrl_if.sv
// Request / board-write bundle between the move engine,
// the randomizer, the board file and the spawner.
interface tile_spawn_ctrl_if;
  import tile_pkg::*;

  logic               spawn_req;
  logic               init_req;
  logic [POS_W-1:0]   rand_pos;
  logic [N_CELLS-1:0] occupancy;
  logic               busy;
  logic               wr_en;
  logic [POS_W-1:0]   wr_pos;
  logic [VAL_W-1:0]   wr_val;
  logic               done;
  logic               board_full;
  logic               req_drop;

  modport master (
    output spawn_req,
    output init_req,
    output rand_pos,
    output occupancy,
    input  busy,
    input  wr_en,
    input  wr_pos,
    input  wr_val,
    input  done,
    input  board_full,
    input  req_drop
  );

  modport slave (
    input  spawn_req,
    input  init_req,
    input  rand_pos,
    input  occupancy,
    output busy,
    output wr_en,
    output wr_pos,
    output wr_val,
    output done,
    output board_full,
    output req_drop
  );

endinterface

// File: rtl/tile_spawn_ctrl_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Maximal length, so it never reaches 0 from a nonzero seed.
module spawn_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       fb;

  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5]
           ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = {lfsr_q[6:0], fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tile_spawn_ctrl.sv
// New-tile placement sequencer for the 4x4 board.
// Snapshot, forward scan with wrap, one write per tile.
module tile_spawn_ctrl
  import tile_pkg::*;
#(
  parameter int         FOUR_THRESH = 2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  tile_spawn_ctrl_if.slave    bus
);

  localparam logic [3:0] THR = 4'(FOUR_THRESH);

  logic [7:0] lfsr;

  spawn_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  state_e             state_q, state_d;
  logic [POS_W-1:0]   idx_q,   idx_d;
  logic [POS_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         rem_q,   rem_d;
  logic [N_CELLS-1:0] snap_q,  snap_d;

  logic               busy_q,  busy_d;
  logic               wr_en_q, wr_en_d;
  logic [POS_W-1:0]   wr_pos_q, wr_pos_d;
  logic [VAL_W-1:0]   wr_val_q, wr_val_d;
  logic               done_q,  done_d;
  logic               full_q,  full_d;
  logic               drop_q,  drop_d;

  logic               req;

  always_comb begin
    req     = bus.spawn_req | bus.init_req;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    snap_d  = snap_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = bus.rand_pos;
          snap_d  = bus.occupancy;
          rem_d   = bus.init_req ? 2'd2 : 2'd1;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!snap_q[idx_q]) begin
          state_d = S_WRITE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_FULL;
        end else begin
          idx_d = pos_inc(idx_q);
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        snap_d[idx_q] = 1'b1;
        rem_d         = rem_q - 2'd1;
        if (rem_q == 2'd2) begin
          idx_d   = bus.rand_pos;
          cnt_d   = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FULL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they
  // line up with the state they describe.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    wr_en_d  = (state_d == S_WRITE);
    wr_pos_d = '0;
    wr_val_d = '0;
    if (state_d == S_WRITE) begin
      wr_pos_d = idx_d;
      wr_val_d = (lfsr[3:0] < THR) ? TILE_4 : TILE_2;
    end
    done_d = (state_d == S_DONE) ||
             (state_d == S_FULL);
    full_d = (state_d == S_FULL);
    drop_d = req && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      snap_q   <= '0;
      busy_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_pos_q <= '0;
      wr_val_q <= '0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      snap_q   <= snap_d;
      busy_q   <= busy_d;
      wr_en_q  <= wr_en_d;
      wr_pos_q <= wr_pos_d;
      wr_val_q <= wr_val_d;
      done_q   <= done_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_pos     = wr_pos_q;
  assign bus.wr_val     = wr_val_q;
  assign bus.done       = done_q;
  assign bus.board_full = full_q;
  assign bus.req_drop   = drop_q;

endmodule

// File: tb/tb_tile_spawn_ctrl.sv
// Self-checking bench for tile_spawn_ctrl.
// Vector table plus drop, mid-reset and tile-ratio sequences.
module tb_tile_spawn_ctrl;
  import tile_pkg::*;

  logic clk;
  logic rst_n;

  tile_spawn_ctrl_if bus ();

  tile_spawn_ctrl #(
    .FOUR_THRESH (2),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] occ;
    logic [3:0]  rp;
    logic        sp;
    logic        in;
    int          nwr;
    int          pos0;
    int          cyc0;
    int          pos1;
    int          cyc1;
    int          dcyc;
    logic        full;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  int   nwr, pos0, cyc0, pos1, cyc1, val0;
  int   done_cyc, busy_bad, val_bad, stray;
  logic full_seen, busy_after;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic run_req(input logic [15:0] occ,
                         input logic [3:0]  rp,
                         input logic        sp,
                         input logic        in);
    nwr = 0; pos0 = -1; cyc0 = -1;
    pos1 = -1; cyc1 = -1; val0 = 0;
    done_cyc = -1; full_seen = 1'b0;
    busy_bad = 0; val_bad = 0; stray = 0;
    bus.occupancy = occ;
    bus.rand_pos  = rp;
    bus.spawn_req = sp;
    bus.init_req  = in;
    @(negedge clk);
    bus.spawn_req = 1'b0;
    bus.init_req  = 1'b0;
    bus.occupancy = ~occ;
    for (int k = 1; k <= 40; k++) begin
      if (!bus.busy) busy_bad++;
      if (bus.board_full && !bus.done) stray++;
      if (bus.wr_en) begin
        if (nwr == 0) begin
          pos0 = int'(bus.wr_pos);
          cyc0 = k;
          val0 = int'(bus.wr_val);
        end else if (nwr == 1) begin
          pos1 = int'(bus.wr_pos);
          cyc1 = k;
        end
        if (bus.wr_val != TILE_2 &&
            bus.wr_val != TILE_4) val_bad++;
        nwr++;
      end
      if (bus.done) begin
        done_cyc  = k;
        full_seen = bus.board_full;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    busy_after = bus.busy;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{16'h0000, 4'd5,  1, 0, 1,  5,  2, -1, -1,  3, 0};
    vt[1] = '{16'h00E0, 4'd5,  1, 0, 1,  8,  5, -1, -1,  6, 0};
    vt[2] = '{16'h8000, 4'd15, 1, 0, 1,  0,  3, -1, -1,  4, 0};
    vt[3] = '{16'hFFFF, 4'd9,  1, 0, 0, -1, -1, -1, -1, 17, 1};
    vt[4] = '{16'h0000, 4'd3,  0, 1, 2,  3,  2,  4,  5,  6, 0};
    vt[5] = '{16'hFFFE, 4'd7,  0, 1, 1,  0, 11, -1, -1, 28, 1};
    vt[6] = '{16'h0000, 4'd10, 1, 1, 2, 10,  2, 11,  5,  6, 0};
    vt[7] = '{16'h7FFF, 4'd0,  1, 0, 1, 15, 17, -1, -1, 18, 0};
    vt[8] = '{16'h0001, 4'd0,  1, 0, 1,  1,  3, -1, -1,  4, 0};

    rst_n = 1'b0;
    bus.spawn_req = 1'b0;
    bus.init_req  = 1'b0;
    bus.rand_pos  = '0;
    bus.occupancy = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs",
        int'({bus.busy, bus.wr_en, bus.wr_pos,
              bus.wr_val, bus.done,
              bus.board_full, bus.req_drop}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);

    foreach (vt[i]) begin
      run_req(vt[i].occ, vt[i].rp,
              vt[i].sp, vt[i].in);
      chk($sformatf("v%0d_nwr", i), nwr, vt[i].nwr);
      chk($sformatf("v%0d_pos0", i), pos0, vt[i].pos0);
      chk($sformatf("v%0d_cyc0", i), cyc0, vt[i].cyc0);
      chk($sformatf("v%0d_pos1", i), pos1, vt[i].pos1);
      chk($sformatf("v%0d_cyc1", i), cyc1, vt[i].cyc1);
      chk($sformatf("v%0d_done", i), done_cyc,
          vt[i].dcyc);
      chk($sformatf("v%0d_full", i), int'(full_seen),
          int'(vt[i].full));
      chk($sformatf("v%0d_busy", i), busy_bad, 0);
      chk($sformatf("v%0d_stray", i), stray, 0);
      chk($sformatf("v%0d_val", i), val_bad, 0);
      chk($sformatf("v%0d_after", i), int'(busy_after), 0);
    end

    // Request arriving during SCAN is dropped.
    bus.occupancy = 16'h00E0;
    bus.rand_pos  = 4'd5;
    bus.spawn_req = 1'b1;
    @(negedge clk);
    bus.spawn_req = 1'b1;
    @(negedge clk);
    bus.spawn_req = 1'b0;
    chk("drop_pulse", int'(bus.req_drop), 1);
    @(negedge clk);
    chk("drop_once", int'(bus.req_drop), 0);
    nwr = 0; pos0 = -1; done_cyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.wr_en) begin
        pos0 = int'(bus.wr_pos);
        nwr++;
      end
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end
    chk("drop_nwr", nwr, 1);
    chk("drop_pos", pos0, 8);
    chk("drop_done_seen", int'(done_cyc >= 0), 1);
    @(negedge clk);

    // Asynchronous reset while scanning a full board.
    bus.occupancy = 16'hFFFF;
    bus.rand_pos  = 4'd2;
    bus.spawn_req = 1'b1;
    @(negedge clk);
    bus.spawn_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("scan_busy", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        int'({bus.busy, bus.wr_en, bus.wr_pos,
              bus.wr_val, bus.done,
              bus.board_full, bus.req_drop}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    chk("post_rst_quiet", stray, 0);
    run_req(16'h0000, 4'd12, 1'b1, 1'b0);
    chk("post_rst_pos", pos0, 12);
    chk("post_rst_cyc", cyc0, 2);
    chk("post_rst_done", done_cyc, 3);

    // Tile-code distribution over many spawns.
    begin
      int fours = 0;
      int bad   = 0;
      int miss  = 0;
      for (int n = 0; n < 10000; n++) begin
        run_req(16'h0000, 4'($urandom_range(0, 15)),
                1'b1, 1'b0);
        if (nwr != 1 || done_cyc != 3) miss++;
        if (val0 == 2) fours++;
        else if (val0 != 1) bad++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk("ratio_miss", miss, 0);
      chk("ratio_bad", bad, 0);
      chk("ratio_low", int'(fours >= 800), 1);
      chk("ratio_high", int'(fours <= 1700), 1);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
